// File: rtl/reflet_float_au_ctrl_if.sv
// Command, arithmetic-unit and result channels of the reflet FPU command sequencer.
// The sequencer uses the slave view; the surrounding system uses the master view.
interface reflet_float_au_ctrl_if #(
    parameter int float_size = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [5:0]            cmd_opcode;
    logic [1:0]            cmd_flag;
    logic [float_size-1:0] cmd_in1;
    logic [float_size-1:0] cmd_in2;
    logic [float_size-1:0] cmd_in3;

    logic                  au_enable;
    logic [5:0]            au_opcode;
    logic [1:0]            au_ctrl_flag;
    logic [float_size-1:0] au_in1;
    logic [float_size-1:0] au_in2;
    logic [float_size-1:0] au_in3;
    logic                  au_ready;
    logic [float_size-1:0] au_out;
    logic                  au_flag;

    logic                  res_valid;
    logic                  res_ready;
    logic [float_size-1:0] res_data;
    logic                  res_flag;
    logic                  res_timeout;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_flag, cmd_in1, cmd_in2, cmd_in3,
        input  au_ready, au_out, au_flag,
        input  res_ready,
        output cmd_ready,
        output au_enable, au_opcode, au_ctrl_flag, au_in1, au_in2, au_in3,
        output res_valid, res_data, res_flag, res_timeout
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_flag, cmd_in1, cmd_in2, cmd_in3,
        output au_ready, au_out, au_flag,
        output res_ready,
        input  cmd_ready,
        input  au_enable, au_opcode, au_ctrl_flag, au_in1, au_in2, au_in3,
        input  res_valid, res_data, res_flag, res_timeout
    );
endinterface

// File: rtl/reflet_float_au_ctrl.sv
// Command sequencer for the reflet FPU arithmetic unit: holds one operation on the unit
// until it reports ready (or the watchdog fires) and hands the result downstream.
module reflet_float_au_ctrl #(
    parameter int float_size     = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    reflet_float_au_ctrl_if.slave bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(timeout_cycles - 1);

    state_t                state;
    logic [15:0]           run_cnt;
    logic                  au_enable_q;
    logic [5:0]            au_opcode_q;
    logic [1:0]            au_ctrl_flag_q;
    logic [float_size-1:0] au_in1_q;
    logic [float_size-1:0] au_in2_q;
    logic [float_size-1:0] au_in3_q;
    logic                  res_valid_q;
    logic [float_size-1:0] res_data_q;
    logic                  res_flag_q;
    logic                  res_timeout_q;
    logic                  cmd_ready_d;
    logic                  take_cmd;

    // A command enters from IDLE, or straight from DONE in the cycle the result is taken.
    assign cmd_ready_d = (state == IDLE) || ((state == DONE) && bus.res_ready);
    assign take_cmd    = cmd_ready_d && bus.cmd_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            run_cnt       <= '0;
            au_enable_q   <= 1'b0;
            busy          <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_flag_q    <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_cmd) begin
                        state       <= RUN;
                        run_cnt     <= '0;
                        au_enable_q <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    // A ready unit wins over the watchdog firing in the same cycle.
                    if (bus.au_ready) begin
                        state         <= DONE;
                        au_enable_q   <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_data_q    <= bus.au_out;
                        res_flag_q    <= bus.au_flag;
                        res_timeout_q <= 1'b0;
                    end else if (run_cnt == LAST_CNT) begin
                        state         <= DONE;
                        au_enable_q   <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_data_q    <= '0;
                        res_flag_q    <= 1'b0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (bus.cmd_valid) begin
                            state       <= RUN;
                            run_cnt     <= '0;
                            au_enable_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    au_enable_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Operands only move on a command handshake, so they stay frozen throughout RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            au_opcode_q    <= '0;
            au_ctrl_flag_q <= '0;
            au_in1_q       <= '0;
            au_in2_q       <= '0;
            au_in3_q       <= '0;
        end else if (take_cmd) begin
            au_opcode_q    <= bus.cmd_opcode;
            au_ctrl_flag_q <= bus.cmd_flag;
            au_in1_q       <= bus.cmd_in1;
            au_in2_q       <= bus.cmd_in2;
            au_in3_q       <= bus.cmd_in3;
        end
    end

    assign bus.cmd_ready    = cmd_ready_d;
    assign bus.au_enable    = au_enable_q;
    assign bus.au_opcode    = au_opcode_q;
    assign bus.au_ctrl_flag = au_ctrl_flag_q;
    assign bus.au_in1       = au_in1_q;
    assign bus.au_in2       = au_in2_q;
    assign bus.au_in3       = au_in3_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_flag     = res_flag_q;
    assign bus.res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_reflet_float_au_ctrl.sv
// Bench for reflet_float_au_ctrl: an arithmetic-unit stub with programmable latency
// sits behind the sequencer, and a latency/timeout model predicts every result.
module tb_reflet_float_au_ctrl;
    localparam int TMO = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    int          vectors     = 0;
    int          miscompares = 0;
    int          stub_lat    = 0;   // unit ready on this enabled cycle; 0 = never ready
    logic [31:0] stub_out    = '0;
    logic        stub_flag   = 1'b0;
    int          en_cnt      = 0;

    reflet_float_au_ctrl_if #(.float_size(32)) bus ();

    reflet_float_au_ctrl #(.float_size(32), .timeout_cycles(TMO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_cnt <= bus.au_enable ? en_cnt + 1 : 0;
    assign bus.au_ready = bus.au_enable && (stub_lat != 0) && (en_cnt + 1 == stub_lat);
    assign bus.au_out   = bus.au_ready ? stub_out : ~stub_out;
    assign bus.au_flag  = bus.au_ready ? stub_flag : ~stub_flag;

    // Expected outcome of one operation: the unit's answer if it arrives within the
    // watchdog window, otherwise a zero result flagged as a timeout after TMO cycles.
    function automatic void model(input int lat, input logic [31:0] o, input logic f,
                                  output int en, output logic [31:0] d,
                                  output logic ef, output logic et);
        if (lat >= 1 && lat <= TMO) begin
            en = lat; d = o; ef = f; et = 1'b0;
        end else begin
            en = TMO; d = '0; ef = 1'b0; et = 1'b1;
        end
    endfunction

    task automatic scramble_cmd();
        bus.cmd_opcode = 6'($urandom);
        bus.cmd_flag   = 2'($urandom);
        bus.cmd_in1    = $urandom;
        bus.cmd_in2    = $urandom;
        bus.cmd_in3    = $urandom;
    endtask

    // Drives one operation end to end and reports what was observed.
    task automatic do_op(input logic [5:0] op, input logic [1:0] fl,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input int lat, input logic [31:0] o, input logic of, input int hold,
                         output int en_cyc, output int lat_cyc, output logic stable,
                         output logic held, output logic [31:0] d, output logic df,
                         output logic dt, output logic ok);
        bit hs;
        ok = 1'b1; stable = 1'b1; held = 1'b1; en_cyc = 0; lat_cyc = 0;
        d = '0; df = 1'b0; dt = 1'b0; hs = 1'b0;
        stub_lat = lat; stub_out = o; stub_flag = of;
        bus.cmd_opcode = op; bus.cmd_flag = fl;
        bus.cmd_in1 = a; bus.cmd_in2 = b; bus.cmd_in3 = c;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        if (!hs) begin ok = 1'b0; return; end
        while (!bus.res_valid && lat_cyc < 300) begin
            if (bus.au_enable) begin
                en_cyc++;
                if (bus.au_opcode !== op || bus.au_ctrl_flag !== fl || bus.au_in1 !== a ||
                    bus.au_in2 !== b || bus.au_in3 !== c) stable = 1'b0;
            end
            @(posedge clk); #1;
            lat_cyc++;
        end
        if (!bus.res_valid) begin ok = 1'b0; return; end
        if (bus.au_enable) en_cyc++;
        d = bus.res_data; df = bus.res_flag; dt = bus.res_timeout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!bus.res_valid || bus.res_data !== d || bus.res_flag !== df ||
                bus.res_timeout !== dt || bus.au_enable || bus.cmd_ready || !busy) held = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (bus.au_enable !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_ctrl en=%b rv=%b busy=%b want 0 0 0", bus.au_enable, bus.res_valid, busy); end
        vectors++; if (bus.res_data !== 32'h0 || bus.res_flag !== 1'b0 || bus.res_timeout !== 1'b0) begin
            miscompares++; $display("FAIL reset_res data=%h flag=%b to=%b want 0 0 0", bus.res_data, bus.res_flag, bus.res_timeout); end
        vectors++; if ({bus.au_opcode, bus.au_ctrl_flag, bus.au_in1, bus.au_in2, bus.au_in3} !== '0) begin
            miscompares++; $display("FAIL reset_au op=%h fl=%h in1=%h want all 0", bus.au_opcode, bus.au_ctrl_flag, bus.au_in1); end
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, busy); end
    endtask

    task automatic test_zero_add();
        int en, lc; logic st, hd, df, dt, ok; logic [31:0] d;
        do_op(6'h00, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 1, 32'h40400000, 1'b0, 0,
              en, lc, st, hd, d, df, dt, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL add_complete got %b want 1", ok); end
        vectors++; if (en !== 1) begin miscompares++; $display("FAIL add_enable_cycles got %0d want 1", en); end
        vectors++; if (lc !== 1) begin miscompares++; $display("FAIL add_latency got %0d want 1", lc); end
        vectors++; if (d !== 32'h40400000 || dt !== 1'b0) begin
            miscompares++; $display("FAIL add_result data=%h to=%b want 40400000 0", d, dt); end
        vectors++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL add_back_idle busy=%b cmd_ready=%b want 0 1", busy, bus.cmd_ready); end
    endtask

    task automatic test_multi_cycle();
        int en, lc; logic st, hd, df, dt, ok; logic [31:0] d;
        do_op(6'h15, 2'b10, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 5, 32'hC0490FDB, 1'b1, 0,
              en, lc, st, hd, d, df, dt, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL multi_complete got %b want 1", ok); end
        vectors++; if (en !== 5 || lc !== 5) begin
            miscompares++; $display("FAIL multi_timing en=%0d lat=%0d want 5 5", en, lc); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL multi_operands_stable got %b want 1", st); end
        vectors++; if (d !== 32'hC0490FDB || df !== 1'b1 || dt !== 1'b0) begin
            miscompares++; $display("FAIL multi_result data=%h flag=%b to=%b want c0490fdb 1 0", d, df, dt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] o, nv; int bad, n;
        o = $urandom; nv = $urandom; bad = 0; n = 0;
        stub_lat = 3; stub_out = o; stub_flag = 1'b1;
        bus.cmd_opcode = 6'h07; bus.cmd_flag = 2'b01;
        bus.cmd_in1 = $urandom; bus.cmd_in2 = $urandom; bus.cmd_in3 = $urandom;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        while (!bus.res_valid && n < 30) begin @(posedge clk); #1; n++; end
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_data !== o) begin
            miscompares++; $display("FAIL bp_first_result rv=%b data=%h want 1 %h", bus.res_valid, bus.res_data, o); end
        bus.cmd_in1 = nv; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b1 || bus.res_data !== o || busy !== 1'b1 ||
                bus.au_enable !== 1'b0 || bus.cmd_ready !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold bad_cycles=%0d want 0", bad); end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0; bus.cmd_valid = 1'b0;
        vectors++; if (bus.au_enable !== 1'b1 || bus.res_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_accept en=%b rv=%b want 1 0", bus.au_enable, bus.res_valid); end
        vectors++; if (bus.au_in1 !== nv) begin
            miscompares++; $display("FAIL bp_new_operand got %h want %h", bus.au_in1, nv); end
        n = 0;
        while (!bus.res_valid && n < 30) begin @(posedge clk); #1; n++; end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        vectors++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_drain busy=%b cmd_ready=%b want 0 1", busy, bus.cmd_ready); end
    endtask

    task automatic test_watchdog();
        int en, lc, lats[3]; logic st, hd, df, dt, ok, ef, et; logic [31:0] d, o, ed; int een;
        lats[0] = 0; lats[1] = TMO; lats[2] = TMO + 1;
        for (int k = 0; k < 3; k++) begin
            o = $urandom | 32'h1;
            do_op(6'($urandom), 2'($urandom), $urandom, $urandom, $urandom, lats[k], o, 1'b1, 0,
                  en, lc, st, hd, d, df, dt, ok);
            model(lats[k], o, 1'b1, een, ed, ef, et);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wd_complete lat=%0d got %b want 1", lats[k], ok); end
            vectors++; if (en !== een || lc !== een) begin
                miscompares++; $display("FAIL wd_timing lat=%0d en=%0d rlat=%0d want %0d", lats[k], en, lc, een); end
            vectors++; if (d !== ed || df !== ef || dt !== et) begin
                miscompares++; $display("FAIL wd_result lat=%0d data=%h flag=%b to=%b want %h %b %b", lats[k], d, df, dt, ed, ef, et); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] o, pend, nxt; int bad_en, bad_rv, bad_in, bad_d;
        o = $urandom; bad_en = 0; bad_rv = 0; bad_in = 0; bad_d = 0;
        stub_lat = 1; stub_out = o; stub_flag = 1'b0;
        bus.res_ready = 1'b1; bus.cmd_valid = 1'b1;
        bus.cmd_in1 = $urandom; pend = bus.cmd_in1;
        @(posedge clk); #1;
        for (int n = 0; n < 12; n++) begin
            if (bus.au_enable !== ((n % 2) == 0)) bad_en++;
            if (bus.res_valid !== ((n % 2) == 1)) bad_rv++;
            if ((n % 2) == 0 && bus.au_in1 !== pend) bad_in++;
            if ((n % 2) == 1 && bus.res_data !== o) bad_d++;
            nxt = $urandom;
            bus.cmd_in1 = nxt;
            if ((n % 2) == 1) pend = nxt;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        vectors++; if (bad_en !== 0) begin miscompares++; $display("FAIL b2b_enable_pattern bad=%0d want 0", bad_en); end
        vectors++; if (bad_rv !== 0) begin miscompares++; $display("FAIL b2b_valid_pattern bad=%0d want 0", bad_rv); end
        vectors++; if (bad_in !== 0) begin miscompares++; $display("FAIL b2b_operands bad=%0d want 0", bad_in); end
        vectors++; if (bad_d !== 0) begin miscompares++; $display("FAIL b2b_results bad=%0d want 0", bad_d); end
        vectors++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_idle busy=%b cmd_ready=%b want 0 1", busy, bus.cmd_ready); end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        bad = 0;
        stub_lat = 0; stub_out = $urandom;
        bus.cmd_in1 = $urandom; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (bus.au_enable !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rst_run_third_cycle en=%b busy=%b want 1 1", bus.au_enable, busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.au_enable !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_async_clear en=%b rv=%b busy=%b want 0 0 0", bus.au_enable, bus.res_valid, busy); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b0 || bus.au_enable !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_no_result bad_cycles=%0d want 0", bad); end
    endtask

    task automatic test_random();
        int en, lc, lat, hold, een; logic st, hd, df, dt, ok, of, ef, et;
        logic [31:0] d, o, ed;
        for (int it = 0; it < 24; it++) begin
            lat = $urandom_range(0, TMO + 3); hold = $urandom_range(0, 3);
            o = $urandom; of = 1'($urandom);
            do_op(6'($urandom), 2'($urandom), $urandom, $urandom, $urandom, lat, o, of, hold,
                  en, lc, st, hd, d, df, dt, ok);
            model(lat, o, of, een, ed, ef, et);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd_complete it=%0d got %b want 1", it, ok); end
            vectors++; if (en !== een || lc !== een) begin
                miscompares++; $display("FAIL rnd_timing it=%0d lat=%0d en=%0d rlat=%0d want %0d", it, lat, en, lc, een); end
            vectors++; if (st !== 1'b1 || hd !== 1'b1) begin
                miscompares++; $display("FAIL rnd_stability it=%0d stable=%b held=%b want 1 1", it, st, hd); end
            vectors++; if (d !== ed || df !== ef || dt !== et) begin
                miscompares++; $display("FAIL rnd_result it=%0d data=%h flag=%b to=%b want %h %b %b", it, d, df, dt, ed, ef, et); end
            vectors++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                miscompares++; $display("FAIL rnd_idle it=%0d busy=%b cmd_ready=%b want 0 1", it, busy, bus.cmd_ready); end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
        bus.cmd_opcode = '0; bus.cmd_flag = '0;
        bus.cmd_in1 = '0; bus.cmd_in2 = '0; bus.cmd_in3 = '0;
        test_reset();
        test_zero_add();
        test_multi_cycle();
        test_backpressure();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached=%0t want finish earlier", $time);
        $fatal(1, "time limit");
    end
endmodule
